// File: rtl/tk1_spi_slave.sv
// Byte-oriented SPI mode-0 responder: oversamples the SPI pins in the clk domain,
// assembles received bytes and serialises response bytes from a one-entry TX buffer.
//   state  | meaning
//   IDLE   | slave not selected, MISO parked low, waiting for SS to fall
//   ACTIVE | slave selected, shifting bits on synchronised SCK edges
module tk1_spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] TX_FILL     = 8'hff
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_ss,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_en,
    output logic [7:0] rx_data,
    output logic       rx_data_vld,
    input  logic       rx_ack,
    input  logic [7:0] tx_data,
    input  logic       tx_data_vld,
    output logic       tx_ready,
    output logic       busy,
    output logic       rx_ovf,
    output logic       tx_udf,
    input  logic       status_clr
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] ss_pipe, sck_pipe, mosi_pipe;
    logic                   ss_last, sck_last;
    logic                   ss_sync, sck_sync, mosi_sync;
    logic                   ss_fall, ss_rise, sck_rise, sck_fall;
    logic [2:0]             bit_ctr;
    logic [7:0]             rx_shift, tx_shift, tx_buf;
    logic                   buf_full;
    logic                   load, rx_rise, tx_shift_en, clear_xfer, rx_done, tx_wr;

    assign ss_sync   = ss_pipe[SYNC_STAGES-1];
    assign sck_sync  = sck_pipe[SYNC_STAGES-1];
    assign mosi_sync = mosi_pipe[SYNC_STAGES-1];
    assign ss_fall   = ss_last & ~ss_sync;
    assign ss_rise   = ~ss_last & ss_sync;
    assign sck_rise  = ~sck_last & sck_sync;
    assign sck_fall  = sck_last & ~sck_sync;

    // SS parks high out of reset so a pin already low still produces a fall edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ss_pipe   <= '1;
            sck_pipe  <= '0;
            mosi_pipe <= '0;
            ss_last   <= 1'b1;
            sck_last  <= 1'b0;
        end else begin
            ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], spi_ss};
            sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], spi_sck};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
            ss_last   <= ss_sync;
            sck_last  <= sck_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next  = state;
        load        = 1'b0;
        rx_rise     = 1'b0;
        tx_shift_en = 1'b0;
        clear_xfer  = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_next = ACTIVE;
                    load       = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_next = IDLE;
                    clear_xfer = 1'b1;
                end else begin
                    rx_rise = sck_rise;
                    // falling edge after the 8th rise is the byte boundary
                    if (sck_fall) begin
                        if (bit_ctr == 3'd0) load        = 1'b1;
                        else                 tx_shift_en = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rx_done = rx_rise && (bit_ctr == 3'd7);
    assign tx_wr   = tx_data_vld && !buf_full;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_ctr     <= 3'd0;
            rx_shift    <= 8'h00;
            tx_shift    <= 8'h00;
            tx_buf      <= 8'h00;
            buf_full    <= 1'b0;
            rx_data     <= 8'h00;
            rx_data_vld <= 1'b0;
            rx_ovf      <= 1'b0;
            tx_udf      <= 1'b0;
        end else begin
            if (state == IDLE || clear_xfer) begin
                bit_ctr  <= 3'd0;
                rx_shift <= 8'h00;
            end else if (rx_rise) begin
                bit_ctr  <= bit_ctr + 3'd1;
                rx_shift <= {rx_shift[6:0], mosi_sync};
            end

            if (load)             tx_shift <= buf_full ? tx_buf : TX_FILL;
            else if (tx_shift_en) tx_shift <= {tx_shift[6:0], 1'b0};
            else if (clear_xfer)  tx_shift <= 8'h00;

            // a write in the same cycle as a load is kept for the following byte
            if (tx_wr) begin
                tx_buf   <= tx_data;
                buf_full <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end

            if (rx_done)     rx_data <= {rx_shift[6:0], mosi_sync};

            if (rx_done)     rx_data_vld <= 1'b1;
            else if (rx_ack) rx_data_vld <= 1'b0;

            if (rx_done && rx_data_vld && !rx_ack) rx_ovf <= 1'b1;
            else if (status_clr)                    rx_ovf <= 1'b0;

            if (load && !buf_full) tx_udf <= 1'b1;
            else if (status_clr)   tx_udf <= 1'b0;
        end
    end

    assign busy        = (state == ACTIVE);
    assign spi_miso_en = busy;
    assign spi_miso    = busy ? tx_shift[7] : 1'b0;
    assign tx_ready    = !buf_full;

endmodule
